// File: rtl/slow_tick_timer.sv
// Synchronizes the divided slow clock, turns each rising edge into a one-cycle
// tick enable, and runs a start/abort countdown timer measured in those ticks.
module slow_tick_timer #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             slowIn,
    input  logic             start,
    input  logic [CNT_W-1:0] load_val,
    input  logic             abort,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_last;
    logic                   prev;
    logic [CNT_W-1:0]       remaining_next;
    logic                   done_next;

    assign sync_last = sync[SYNC_STAGES-1];

    // slowIn is asynchronous data; bit 0 is the first metastability-catching flop
    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            sync <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], slowIn};
            prev <= sync_last;
            tick <= sync_last & ~prev;
        end
    end

    always_ff @(posedge clkIn or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            done      <= done_next;
        end
    end

    // In RUN, abort beats start, which beats tick; remaining is never 0 while in RUN
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        done_next      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        state_next     = RUN;
                        remaining_next = load_val;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end else if (start) begin
                    if (load_val != '0) begin
                        remaining_next = load_val;
                    end else begin
                        state_next     = IDLE;
                        remaining_next = '0;
                        done_next      = 1'b1;
                    end
                end else if (tick) begin
                    if (remaining > CNT_W'(1)) begin
                        remaining_next = remaining - CNT_W'(1);
                    end else begin
                        state_next     = IDLE;
                        remaining_next = '0;
                        done_next      = 1'b1;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                remaining_next = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

endmodule

// File: tb/tb_slow_tick_timer.sv
// Directed self-checking bench for slow_tick_timer: edge detection, countdown,
// zero load, abort, restart and asynchronous reset during a count.
module tb_slow_tick_timer;

    localparam int CNT_W = 8;

    logic             clkIn;
    logic             reset;
    logic             slowIn;
    logic             start;
    logic [CNT_W-1:0] load_val;
    logic             abort;
    logic             tick;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] remaining;

    int checks;
    int errors;

    slow_tick_timer #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clkIn    (clkIn),
        .reset    (reset),
        .slowIn   (slowIn),
        .start    (start),
        .load_val (load_val),
        .abort    (abort),
        .tick     (tick),
        .busy     (busy),
        .done     (done),
        .remaining(remaining)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    // Advance one clock and land just after the edge, where outputs are stable
    task automatic cyc();
        @(posedge clkIn);
        #1;
    endtask

    // Raise slowIn; the tick is high after the third edge and consumed on the fourth
    task automatic send_tick();
        slowIn = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic settle();
        slowIn = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic test_reset();
        reset = 1'b1; slowIn = 1'b0; start = 1'b0; abort = 1'b0; load_val = '0;
        repeat (3) cyc();
        checks++;
        if ({tick, busy, done, remaining} !== {3'b000, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got tick=%b busy=%b done=%b rem=%0d, want all 0",
                     tick, busy, done, remaining);
        end
        reset = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_edge();
        for (int p = 0; p < 2; p++) begin
            slowIn = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                cyc();
                checks++;
                if (tick !== (k == 3)) begin
                    errors++;
                    $display("[TB] FAIL edge_rise p=%0d k=%0d: tick=%b want %b", p, k, tick, (k == 3));
                end
            end
            slowIn = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                cyc();
                checks++;
                if (tick !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL edge_fall p=%0d k=%0d: tick=%b want 0", p, k, tick);
                end
            end
        end
    endtask

    task automatic test_count();
        start = 1'b1; load_val = 8'd3;
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, done, remaining} !== {2'b10, 8'd3}) begin
            errors++;
            $display("[TB] FAIL count_load: busy=%b done=%b rem=%0d want 1 0 3", busy, done, remaining);
        end
        for (int i = 0; i < 3; i++) begin
            send_tick();
            checks++;
            if (remaining !== 8'(2 - i) || busy !== (i < 2) || done !== (i == 2)) begin
                errors++;
                $display("[TB] FAIL count_step %0d: rem=%0d busy=%b done=%b want %0d %b %b",
                         i, remaining, busy, done, 2 - i, (i < 2), (i == 2));
            end
            settle();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL count_done_width %0d: done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_zero();
        start = 1'b1; load_val = 8'd0;
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, done, remaining} !== {2'b01, 8'd0}) begin
            errors++;
            $display("[TB] FAIL zero_load: busy=%b done=%b rem=%0d want 0 1 0", busy, done, remaining);
        end
        cyc();
        checks++;
        if ({busy, done, remaining} !== {2'b00, 8'd0}) begin
            errors++;
            $display("[TB] FAIL zero_after: busy=%b done=%b rem=%0d want 0 0 0", busy, done, remaining);
        end
    endtask

    task automatic test_abort();
        start = 1'b1; load_val = 8'd5;
        cyc();
        start = 1'b0;
        repeat (2) begin
            send_tick();
            settle();
        end
        checks++;
        if (remaining !== 8'd3) begin
            errors++;
            $display("[TB] FAIL abort_pre: rem=%0d want 3", remaining);
        end
        slowIn = 1'b1;
        repeat (3) cyc();
        checks++;
        if (tick !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_tick: tick=%b want 1", tick);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        checks++;
        if ({busy, done, remaining} !== {2'b00, 8'd0}) begin
            errors++;
            $display("[TB] FAIL abort_result: busy=%b done=%b rem=%0d want 0 0 0", busy, done, remaining);
        end
        slowIn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort_no_done %0d: done=%b want 0", k, done);
            end
        end
    endtask

    task automatic test_restart();
        start = 1'b1; load_val = 8'd4;
        cyc();
        start = 1'b0;
        send_tick();
        settle();
        checks++;
        if (remaining !== 8'd3) begin
            errors++;
            $display("[TB] FAIL restart_pre: rem=%0d want 3", remaining);
        end
        slowIn = 1'b1;
        repeat (3) cyc();
        start = 1'b1; load_val = 8'd2;
        cyc();
        start = 1'b0;
        checks++;
        if ({busy, done, remaining} !== {2'b10, 8'd2}) begin
            errors++;
            $display("[TB] FAIL restart_load: busy=%b done=%b rem=%0d want 1 0 2", busy, done, remaining);
        end
        settle();
        send_tick();
        checks++;
        if ({busy, done, remaining} !== {2'b10, 8'd1}) begin
            errors++;
            $display("[TB] FAIL restart_step1: busy=%b done=%b rem=%0d want 1 0 1", busy, done, remaining);
        end
        settle();
        send_tick();
        checks++;
        if ({busy, done, remaining} !== {2'b01, 8'd0}) begin
            errors++;
            $display("[TB] FAIL restart_final: busy=%b done=%b rem=%0d want 0 1 0", busy, done, remaining);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        start = 1'b1; load_val = 8'd7;
        cyc();
        start = 1'b0;
        checks++;
        if (remaining !== 8'd7) begin
            errors++;
            $display("[TB] FAIL midreset_load: rem=%0d want 7", remaining);
        end
        slowIn = 1'b1;
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({tick, busy, done, remaining} !== {3'b000, 8'd0}) begin
                errors++;
                $display("[TB] FAIL midreset_hold %0d: tick=%b busy=%b done=%b rem=%0d want all 0",
                         k, tick, busy, done, remaining);
            end
            cyc();
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            checks++;
            if (tick !== (k == 3) || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_release k=%0d: tick=%b busy=%b done=%b want %b 0 0",
                         k, tick, busy, done, (k == 3));
            end
        end
        settle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_edge();
        test_count();
        test_zero();
        test_abort();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
